// File: rtl/hazard_scoreboard_pkg.sv
// Shared cpu types for the hazard/scoreboard unit.
// Forward-select codes and the register index type.
package hazard_scoreboard_pkg;

  localparam int CPU_NREG = 32;
  localparam int CPU_RW   = $clog2(CPU_NREG);

  typedef logic [CPU_RW-1:0] Gr;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } FwdSel;

endpackage

// File: rtl/hazard_scoreboard_fetch_cancel_ctr.sv
// Outstanding-fetch counter and stale-response cancel counter.
// Drops responses belonging to requests issued before a redirect.
module fetch_cancel_ctr #(
  parameter int MAX_OUT = 2,
  parameter int CW      = $clog2(MAX_OUT+1)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_addr_ok,
  input  logic i_data_ok,
  input  logic i_redirect,
  output logic o_drop,
  output logic o_req_block
);

  logic [CW-1:0] r_out;
  logic [CW-1:0] r_cancel;
  logic [CW-1:0] w_out_next;

  assign w_out_next = r_out + CW'(i_addr_ok) - CW'(i_data_ok);
  assign o_drop = ~i_reset & i_data_ok & (r_cancel != '0);
  assign o_req_block = ~i_reset & (r_out == CW'(MAX_OUT));

  // Track in-flight requests; reload cancel count on redirect.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out    <= '0;
      r_cancel <= '0;
    end else begin
      r_out <= w_out_next;
      if (i_redirect)
        r_cancel <= w_out_next;
      else if (o_drop)
        r_cancel <= r_cancel - CW'(1);
    end
  end

  a_no_overreq: assert property (
    @(posedge i_clk) disable iff (i_reset)
    !(i_addr_ok && o_req_block));

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding selects, ID stall, long-op scoreboard and flushes.
// Fetch cancel bookkeeping lives in fetch_cancel_ctr.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int RW      = $clog2(NREG),
  parameter int NSRC    = 3,
  parameter int MAX_OUT = 2,
  parameter int CW      = $clog2(MAX_OUT+1)
) (
  input  logic                     aclk,
  input  logic                     reset,
  input  logic                     i_id_valid,
  input  logic                     i_id_early,
  input  logic [NSRC-1:0]          i_id_src_en,
  input  logic [NSRC-1:0][RW-1:0]  i_id_src,
  input  logic                     i_id_dst_en,
  input  logic [RW-1:0]            i_id_dst,
  input  logic                     i_id_long,
  input  logic                     i_id_redirect,
  input  logic                     i_ex_allow_in,
  input  logic                     i_ex_valid,
  input  logic                     i_ex_dst_en,
  input  logic [RW-1:0]            i_ex_dst,
  input  logic                     i_mem_valid,
  input  logic                     i_mem_dst_en,
  input  logic [RW-1:0]            i_mem_dst,
  input  logic                     i_wb_valid,
  input  logic                     i_wb_dst_en,
  input  logic [RW-1:0]            i_wb_dst,
  input  logic                     i_ex_fwd_ok,
  input  logic                     i_mem_fwd_ok,
  input  logic                     i_lu_done,
  input  logic [RW-1:0]            i_lu_dst,
  input  logic                     i_mem_exc,
  input  logic                     i_mem_ertn,
  input  logic                     i_mem_idle,
  input  logic                     i_wb_exc,
  input  logic                     i_wb_ertn,
  input  logic                     i_wb_idle,
  input  logic                     i_if_addr_ok,
  input  logic                     i_if_data_ok,
  output logic [NSRC-1:0][1:0]     o_fwd_sel,
  output logic                     o_id_stall,
  output logic                     o_if_flush,
  output logic                     o_id_flush,
  output logic                     o_ex_flush,
  output logic                     o_mem_flush,
  output logic                     o_if_drop,
  output logic                     o_if_req_block
);

  logic [NREG-1:0]        r_pend;
  logic [NSRC-1:0][1:0]   w_sel;
  logic [NSRC-1:0]        w_src_hz;
  logic                   w_waw;
  logic                   w_wb_fl;
  logic                   w_flush_all;
  logic                   w_stall;
  logic                   w_issue;
  logic                   w_redirect;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    logic w_use;
    logic w_mex;
    logic w_mmem;
    logic w_mwb;
    logic w_pipe_hz;
    assign w_use  = i_id_src_en[s] & (i_id_src[s] != '0);
    assign w_mex  = w_use & i_ex_valid & i_ex_dst_en
                  & (i_ex_dst == i_id_src[s]);
    assign w_mmem = w_use & i_mem_valid & i_mem_dst_en
                  & (i_mem_dst == i_id_src[s]);
    assign w_mwb  = w_use & i_wb_valid & i_wb_dst_en
                  & (i_wb_dst == i_id_src[s]);
    assign w_sel[s] = w_mex  ? FWD_EX  :
                      w_mmem ? FWD_MEM :
                      w_mwb  ? FWD_WB  : FWD_RF;
    // Early consumers cannot take EX results; later ones wait
    // only for results that are not final yet.
    assign w_pipe_hz = i_id_early
      ? (w_mex | (w_mmem & ~i_mem_fwd_ok))
      : ((w_mex & ~i_ex_fwd_ok)
         | (~w_mex & w_mmem & ~i_mem_fwd_ok));
    assign w_src_hz[s] = w_pipe_hz
                       | (w_use & r_pend[i_id_src[s]]);
  end

  assign w_waw = i_id_dst_en & r_pend[i_id_dst];
  assign w_wb_fl = i_wb_exc | i_wb_ertn | i_wb_idle;
  assign w_flush_all = w_wb_fl | i_mem_exc | i_mem_ertn
                     | i_mem_idle;
  assign w_stall = i_id_valid & ((|w_src_hz) | w_waw)
                 & ~w_flush_all;
  assign w_issue = i_id_valid & ~w_stall & i_ex_allow_in
                 & ~w_flush_all;
  assign w_redirect = (w_issue & i_id_redirect) | w_flush_all;

  assign o_fwd_sel   = reset ? '0 : w_sel;
  assign o_id_stall  = ~reset & w_stall;
  assign o_if_flush  = reset | w_flush_all;
  assign o_id_flush  = reset | w_flush_all;
  assign o_ex_flush  = reset | w_flush_all;
  assign o_mem_flush = reset | w_wb_fl;

  // Mark long-latency destinations busy until the unit writes back.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      if (i_lu_done)
        r_pend[i_lu_dst] <= 1'b0;
      if (w_issue & i_id_long & (i_id_dst != '0))
        r_pend[i_id_dst] <= 1'b1;
    end
  end

  fetch_cancel_ctr #(
    .MAX_OUT (MAX_OUT),
    .CW      (CW)
  ) u_fetch_cancel_ctr (
    .i_clk       (aclk),
    .i_reset     (reset),
    .i_addr_ok   (i_if_addr_ok),
    .i_data_ok   (i_if_data_ok),
    .i_redirect  (w_redirect),
    .o_drop      (o_if_drop),
    .o_req_block (o_if_req_block)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Expectations are queued by stimulus and checked by a monitor.
module tb_hazard_scoreboard;

  logic aclk = 1'b0;
  logic reset;
  logic id_valid, id_early, id_dst_en, id_long, id_redirect;
  logic [2:0] src_en;
  logic [2:0][4:0] src;
  logic [4:0] id_dst, ex_dst, mem_dst, wb_dst, lu_dst;
  logic ex_allow_in;
  logic ex_valid, ex_dst_en, mem_valid, mem_dst_en;
  logic wb_valid, wb_dst_en, ex_fwd_ok, mem_fwd_ok, lu_done;
  logic mem_exc, mem_ertn, mem_idle, wb_exc, wb_ertn, wb_idle;
  logic addr_ok, data_ok;
  logic [2:0][1:0] fwd_sel;
  logic id_stall, if_flush, id_flush, ex_flush, mem_flush;
  logic if_drop, if_req_block;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string      nm;
    logic [12:0] v;
  } exp_t;
  exp_t q[$];

  always #5 aclk = ~aclk;

  hazard_scoreboard dut (
    .aclk(aclk), .reset(reset),
    .i_id_valid(id_valid), .i_id_early(id_early),
    .i_id_src_en(src_en), .i_id_src(src),
    .i_id_dst_en(id_dst_en), .i_id_dst(id_dst),
    .i_id_long(id_long), .i_id_redirect(id_redirect),
    .i_ex_allow_in(ex_allow_in),
    .i_ex_valid(ex_valid), .i_ex_dst_en(ex_dst_en),
    .i_ex_dst(ex_dst),
    .i_mem_valid(mem_valid), .i_mem_dst_en(mem_dst_en),
    .i_mem_dst(mem_dst),
    .i_wb_valid(wb_valid), .i_wb_dst_en(wb_dst_en),
    .i_wb_dst(wb_dst),
    .i_ex_fwd_ok(ex_fwd_ok), .i_mem_fwd_ok(mem_fwd_ok),
    .i_lu_done(lu_done), .i_lu_dst(lu_dst),
    .i_mem_exc(mem_exc), .i_mem_ertn(mem_ertn),
    .i_mem_idle(mem_idle),
    .i_wb_exc(wb_exc), .i_wb_ertn(wb_ertn),
    .i_wb_idle(wb_idle),
    .i_if_addr_ok(addr_ok), .i_if_data_ok(data_ok),
    .o_fwd_sel(fwd_sel), .o_id_stall(id_stall),
    .o_if_flush(if_flush), .o_id_flush(id_flush),
    .o_ex_flush(ex_flush), .o_mem_flush(mem_flush),
    .o_if_drop(if_drop), .o_if_req_block(if_req_block)
  );

  logic [12:0] got;
  assign got = {fwd_sel, id_stall, if_flush, id_flush,
                ex_flush, mem_flush, if_drop, if_req_block};

  // monitor: one queued expectation per cycle, mid-cycle
  always @(negedge aclk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got fwd/st/fl/dr/bl=%b required %b",
                 e.nm, got, e.v);
      end
    end
  end

  task automatic clr();
    id_valid = 0; id_early = 0; id_dst_en = 0; id_long = 0;
    id_redirect = 0; src_en = '0; src = '0; id_dst = '0;
    ex_allow_in = 1;
    ex_valid = 0; ex_dst_en = 0; ex_dst = '0;
    mem_valid = 0; mem_dst_en = 0; mem_dst = '0;
    wb_valid = 0; wb_dst_en = 0; wb_dst = '0;
    ex_fwd_ok = 0; mem_fwd_ok = 0; lu_done = 0; lu_dst = '0;
    mem_exc = 0; mem_ertn = 0; mem_idle = 0;
    wb_exc = 0; wb_ertn = 0; wb_idle = 0;
    addr_ok = 0; data_ok = 0;
  endtask

  task automatic chk(input string nm, input logic [5:0] f,
                     input logic st, input logic [3:0] fl,
                     input logic dr, input logic bl);
    exp_t e;
    e.nm = nm;
    e.v = {f, st, fl, dr, bl};
    q.push_back(e);
    @(posedge aclk);
    #1;
  endtask

  task automatic ex_w(input logic [4:0] r, input logic ok);
    ex_valid = 1; ex_dst_en = 1; ex_dst = r; ex_fwd_ok = ok;
  endtask

  task automatic mem_w(input logic [4:0] r, input logic ok);
    mem_valid = 1; mem_dst_en = 1; mem_dst = r; mem_fwd_ok = ok;
  endtask

  initial begin
    clr();
    reset = 1;
    @(posedge aclk);
    #1;
    // reset gating with hazards present
    id_valid = 1; src_en[0] = 1; src[0] = 5'd5;
    ex_w(5'd5, 0); data_ok = 1;
    chk("reset0", 6'b0, 0, 4'b1111, 0, 0);
    chk("reset1", 6'b0, 0, 4'b1111, 0, 0);
    reset = 0;
    clr();

    // forwarding / stalls
    id_valid = 1; src_en[1] = 1; src[1] = 5'd5; ex_w(5'd5, 1);
    chk("ex_alu_fwd", 6'b000100, 0, 4'b0, 0, 0);
    ex_fwd_ok = 0;
    chk("ex_load_stall", 6'b000100, 1, 4'b0, 0, 0);
    ex_valid = 0; mem_w(5'd5, 1);
    chk("mem_load_fwd", 6'b001000, 0, 4'b0, 0, 0);
    mem_fwd_ok = 0;
    chk("mem_notok_stall", 6'b001000, 1, 4'b0, 0, 0);
    id_valid = 0;
    chk("no_valid_nostall", 6'b001000, 0, 4'b0, 0, 0);
    clr();
    id_valid = 1; id_early = 1; src_en[0] = 1; src[0] = 5'd7;
    ex_w(5'd7, 1);
    chk("early_ex_stall", 6'b000001, 1, 4'b0, 0, 0);
    ex_valid = 0; mem_w(5'd7, 1);
    chk("early_mem_fwd", 6'b000010, 0, 4'b0, 0, 0);
    mem_fwd_ok = 0;
    chk("early_mem_stall", 6'b000010, 1, 4'b0, 0, 0);
    mem_valid = 0; wb_valid = 1; wb_dst_en = 1; wb_dst = 5'd7;
    chk("early_wb_fwd", 6'b000011, 0, 4'b0, 0, 0);
    clr();
    id_valid = 1; src_en[2] = 1; src[2] = 5'd3;
    ex_w(5'd3, 1); mem_w(5'd3, 1);
    wb_valid = 1; wb_dst_en = 1; wb_dst = 5'd3;
    chk("prio_ex", 6'b010000, 0, 4'b0, 0, 0);
    ex_valid = 0;
    chk("prio_mem", 6'b100000, 0, 4'b0, 0, 0);
    mem_valid = 0;
    chk("prio_wb", 6'b110000, 0, 4'b0, 0, 0);
    clr();
    id_valid = 1; src_en[0] = 1; src[0] = 5'd0; ex_w(5'd0, 0);
    chk("r0_never", 6'b0, 0, 4'b0, 0, 0);

    // long-latency scoreboard
    clr();
    id_valid = 1; id_dst_en = 1; id_dst = 5'd9; id_long = 1;
    chk("div_issue", 6'b0, 0, 4'b0, 0, 0);
    clr();
    id_valid = 1; src_en[2] = 1; src[2] = 5'd9;
    chk("div_raw", 6'b0, 1, 4'b0, 0, 0);
    lu_done = 1; lu_dst = 5'd9;
    chk("div_raw_done", 6'b0, 1, 4'b0, 0, 0);
    lu_done = 0;
    chk("div_raw_clear", 6'b0, 0, 4'b0, 0, 0);
    clr();
    id_valid = 1; id_dst_en = 1; id_dst = 5'd10; id_long = 1;
    chk("div2_issue", 6'b0, 0, 4'b0, 0, 0);
    id_long = 0;
    chk("waw_stall", 6'b0, 1, 4'b0, 0, 0);
    lu_done = 1; lu_dst = 5'd10;
    chk("waw_done", 6'b0, 1, 4'b0, 0, 0);
    lu_done = 0;
    chk("waw_clear", 6'b0, 0, 4'b0, 0, 0);

    // fetch cancel
    clr();
    addr_ok = 1;
    chk("addr0", 6'b0, 0, 4'b0, 0, 0);
    chk("addr1", 6'b0, 0, 4'b0, 0, 0);
    clr();
    id_valid = 1; id_redirect = 1;
    chk("redirect_block", 6'b0, 0, 4'b0, 0, 1);
    clr();
    data_ok = 1;
    chk("drop1", 6'b0, 0, 4'b0, 1, 1);
    chk("drop2", 6'b0, 0, 4'b0, 1, 0);
    clr();
    addr_ok = 1;
    chk("addr_new", 6'b0, 0, 4'b0, 0, 0);
    clr();
    data_ok = 1;
    chk("nodrop3", 6'b0, 0, 4'b0, 0, 0);
    clr();
    addr_ok = 1;
    chk("addr_s", 6'b0, 0, 4'b0, 0, 0);
    clr();
    id_valid = 1; id_redirect = 1; src_en[0] = 1;
    src[0] = 5'd5; ex_w(5'd5, 0);
    chk("redir_stalled", 6'b000001, 1, 4'b0, 0, 0);
    clr();
    data_ok = 1;
    chk("redir_ignored", 6'b0, 0, 4'b0, 0, 0);

    // flush priority
    clr();
    addr_ok = 1;
    chk("addr_f0", 6'b0, 0, 4'b0, 0, 0);
    chk("addr_f1", 6'b0, 0, 4'b0, 0, 0);
    clr();
    wb_exc = 1; id_valid = 1; src_en[1] = 1; src[1] = 5'd5;
    ex_w(5'd5, 0);
    id_dst_en = 1; id_dst = 5'd12; id_long = 1; data_ok = 1;
    chk("wb_exc_flush", 6'b000100, 0, 4'b1111, 0, 1);
    clr();
    id_valid = 1; src_en[0] = 1; src[0] = 5'd12; data_ok = 1;
    chk("exc_drop_noissue", 6'b0, 0, 4'b0, 1, 0);
    clr();
    mem_ertn = 1; addr_ok = 1;
    chk("mem_ertn_flush", 6'b0, 0, 4'b1110, 0, 0);
    clr();
    data_ok = 1;
    chk("ertn_drop", 6'b0, 0, 4'b0, 1, 0);

    // reset mid-operation clears the scoreboard
    clr();
    id_valid = 1; id_dst_en = 1; id_dst = 5'd11; id_long = 1;
    chk("div3_issue", 6'b0, 0, 4'b0, 0, 0);
    clr();
    reset = 1;
    chk("reset_mid", 6'b0, 0, 4'b1111, 0, 0);
    reset = 0;
    id_valid = 1; src_en[1] = 1; src[1] = 5'd11;
    chk("after_reset", 6'b0, 0, 4'b0, 0, 0);
    clr();

    repeat (2) @(posedge aclk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL queue_drain: got %0d left required 0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
